// File: rtl/video_timing_pkg.sv
// Shared timing types and constants for the video sync generator.
//   timing_t     : active / front porch / sync / total for one axis
//   H_720P/V_720P: power-on shadow timing
//   cfg_state_e  : config handshake states
//   BAR_*        : colour-bar palette for the optional test pattern
package video_timing_pkg;

  localparam int unsigned CW = 12;
  // Validation sums need two extra bits: three CW-bit terms can exceed 2^(CW+1).
  localparam int unsigned VW = CW + 2;

  typedef struct packed {
    logic [CW-1:0] active;
    logic [CW-1:0] fp;
    logic [CW-1:0] sync;
    logic [CW-1:0] total;
  } timing_t;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_e;

  localparam timing_t H_720P = '{active: CW'(1280), fp: CW'(110), sync: CW'(40), total: CW'(1650)};
  localparam timing_t V_720P = '{active: CW'(720),  fp: CW'(5),   sync: CW'(5),  total: CW'(750)};

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // An axis is usable when it has visible pixels, a sync pulse and ends before wrap.
  function automatic logic timing_ok(timing_t t);
    logic [VW-1:0] sum;
    sum = VW'(t.active) + VW'(t.fp) + VW'(t.sync);
    return (sum < VW'(t.total)) && (t.active != '0) && (t.sync != '0);
  endfunction

  function automatic logic [23:0] bar_colour(logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/sync_axis_decode.sv
// Combinational decode of one timing axis (used for both H and V).
//   count   : current position on the axis
//   tim     : shadow timing for the axis
//   act     : count is inside the active region
//   sync_on : count is inside the sync pulse
module sync_axis_decode
  import video_timing_pkg::*;
(
  input  logic [CW-1:0] count,
  input  timing_t       tim,
  output logic          act,
  output logic          sync_on
);

  localparam int unsigned SW = CW + 1;

  logic [SW-1:0] sync_start;
  logic [SW-1:0] sync_end;
  logic          unused_total;

  assign sync_start = SW'(tim.active) + SW'(tim.fp);
  assign sync_end   = sync_start + SW'(tim.sync);

  assign act     = (count < tim.active);
  assign sync_on = (SW'(count) >= sync_start) && (SW'(count) < sync_end);

  // Total only matters to the counters upstream; counts past it fall outside every range.
  assign unused_total = ^tim.total;

endmodule

// File: rtl/video_sync_gen.sv
// Video sync generator: decodes h_count/v_count from pixel_counters into
// registered hsync/vsync/de/x/y using shadow timing that changes only at
// frame_start, and feeds the shadow totals back to the counters.
//   pixel_clk, rst          : clock, synchronous active-high reset
//   h_count, v_count        : counter positions; frame_start marks (0,0)
//   cfg_*_{h,v}, cfg_load   : requested timing and load strobe
//   cfg_busy, cfg_err       : request pending / last request rejected (sticky)
//   h_total, v_total        : shadow totals back to pixel_counters
//   hsync, vsync, de, x, y  : registered outputs, 1 cycle after the counts
//   rgb                     : colour bars, only with VIDEO_SYNC_GEN_PATTERN_EN
module video_sync_gen #(
  parameter int unsigned CW     = video_timing_pkg::CW,
  parameter logic        HS_POL = 1'b1,
  parameter logic        VS_POL = 1'b1
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic [CW-1:0] h_count,
  input  logic [CW-1:0] v_count,
  input  logic          frame_start,
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_total,
  input  logic [CW-1:0] cfg_v_active,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_total,
  input  logic          cfg_load,
  output logic          cfg_busy,
  output logic          cfg_err,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_total,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
`ifdef VIDEO_SYNC_GEN_PATTERN_EN
  output logic [23:0]   rgb,
`endif
  output logic [CW-1:0] y
);

  import video_timing_pkg::*;

  timing_t    h_req_c, v_req_c;
  logic       req_ok_c;
  cfg_state_e state_q;
  timing_t    h_shadow_q, v_shadow_q;
  timing_t    h_stage_q, v_stage_q;
  logic       cfg_err_q;

  assign h_req_c  = '{active: cfg_h_active, fp: cfg_h_fp, sync: cfg_h_sync, total: cfg_h_total};
  assign v_req_c  = '{active: cfg_v_active, fp: cfg_v_fp, sync: cfg_v_sync, total: cfg_v_total};
  assign req_ok_c = timing_ok(h_req_c) && timing_ok(v_req_c);

  // Config handshake: a frame_start apply happens first, then any new request
  // in the same cycle overrides the next state and refills staging.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q    <= CFG_IDLE;
      h_shadow_q <= H_720P;
      v_shadow_q <= V_720P;
      h_stage_q  <= H_720P;
      v_stage_q  <= V_720P;
      cfg_err_q  <= 1'b0;
    end else begin
      if (state_q == CFG_PENDING && frame_start) begin
        h_shadow_q <= h_stage_q;
        v_shadow_q <= v_stage_q;
        state_q    <= CFG_IDLE;
      end
      if (cfg_load) begin
        if (req_ok_c) begin
          h_stage_q <= h_req_c;
          v_stage_q <= v_req_c;
          state_q   <= CFG_PENDING;
          cfg_err_q <= 1'b0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
    end
  end

  assign cfg_busy = (state_q == CFG_PENDING);
  assign cfg_err  = cfg_err_q;
  assign h_total  = h_shadow_q.total;
  assign v_total  = v_shadow_q.total;

  logic h_act_c, hs_on_c, v_act_c, vs_on_c, de_c;

  sync_axis_decode u_h_decode (
    .count   (h_count),
    .tim     (h_shadow_q),
    .act     (h_act_c),
    .sync_on (hs_on_c)
  );

  sync_axis_decode u_v_decode (
    .count   (v_count),
    .tim     (v_shadow_q),
    .act     (v_act_c),
    .sync_on (vs_on_c)
  );

  assign de_c = h_act_c & v_act_c;

  logic          hsync_q, vsync_q, de_q;
  logic [CW-1:0] x_q, y_q;

  // Output stage: one register after the counts.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      hsync_q <= hs_on_c ? HS_POL : ~HS_POL;
      vsync_q <= vs_on_c ? VS_POL : ~VS_POL;
      de_q    <= de_c;
      x_q     <= de_c ? h_count : '0;
      y_q     <= de_c ? v_count : '0;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign x     = x_q;
  assign y     = y_q;

`ifdef VIDEO_SYNC_GEN_PATTERN_EN
  logic [CW-1:0] bar_w_c;
  logic [CW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [23:0]   rgb_q;

  assign bar_w_c = h_shadow_q.active >> 3;

  // Bar position restarts on every de rise; pixels past the 8th bar stay black.
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (de_c && !de_q) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (de_c) begin
      if (bar_cnt_q == bar_w_c - CW'(1)) begin
        bar_cnt_d = '0;
        if (bar_idx_q != 3'd7) begin
          bar_idx_d = bar_idx_q + 3'd1;
        end
      end else begin
        bar_cnt_d = bar_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      rgb_q     <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      rgb_q     <= de_c ? bar_colour(bar_idx_d) : 24'h000000;
    end
  end

  assign rgb = rgb_q;
`else
  // Pattern generator not built.
`endif

endmodule

// File: tb/tb_video_sync_gen.sv
// Self-checking bench for video_sync_gen: reference model of the timing
// rules, table of decode vectors, directed config sequences, random stimulus.
module tb_video_sync_gen;

  localparam int   CW     = 12;
  localparam logic HS_POL = 1'b1;
  localparam logic VS_POL = 1'b1;

  typedef struct {
    int a;
    int fp;
    int s;
    int t;
  } tm_t;

  typedef struct {
    int hc;
    int vc;
    bit hs;
    bit vs;
    bit de;
  } vec_t;

  logic          pixel_clk = 1'b0;
  logic          rst, frame_start, cfg_load;
  logic [CW-1:0] h_count, v_count;
  logic [CW-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_total;
  logic [CW-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_total;
  logic          cfg_busy, cfg_err, hsync, vsync, de;
  logic [CW-1:0] h_total, v_total, x, y;
`ifdef VIDEO_SYNC_GEN_PATTERN_EN
  logic [23:0]   rgb;
`endif

  always #5 pixel_clk = ~pixel_clk;

  video_sync_gen #(.CW(CW), .HS_POL(HS_POL), .VS_POL(VS_POL)) dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .h_count      (h_count),
    .v_count      (v_count),
    .frame_start  (frame_start),
    .cfg_h_active (cfg_h_active),
    .cfg_h_fp     (cfg_h_fp),
    .cfg_h_sync   (cfg_h_sync),
    .cfg_h_total  (cfg_h_total),
    .cfg_v_active (cfg_v_active),
    .cfg_v_fp     (cfg_v_fp),
    .cfg_v_sync   (cfg_v_sync),
    .cfg_v_total  (cfg_v_total),
    .cfg_load     (cfg_load),
    .cfg_busy     (cfg_busy),
    .cfg_err      (cfg_err),
    .h_total      (h_total),
    .v_total      (v_total),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .x            (x),
`ifdef VIDEO_SYNC_GEN_PATTERN_EN
    .rgb          (rgb),
`endif
    .y            (y)
  );

  int  checks   = 0;
  int  failures = 0;
  bit  free_run = 1'b1;
  tm_t m_sh_h, m_sh_v, m_st_h, m_st_v;
  bit  m_pend, m_err;

  function automatic tm_t mk(int a, int fp, int s, int t);
    tm_t r;
    r.a = a; r.fp = fp; r.s = s; r.t = t;
    return r;
  endfunction

  function automatic bit legal(tm_t t);
    return (t.a + t.fp + t.s < t.t) && (t.a != 0) && (t.s != 0);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic set_cfg(input int ha, hf, hs, ht, va, vf, vs, vt);
    cfg_h_active = CW'(ha); cfg_h_fp = CW'(hf); cfg_h_sync = CW'(hs); cfg_h_total = CW'(ht);
    cfg_v_active = CW'(va); cfg_v_fp = CW'(vf); cfg_v_sync = CW'(vs); cfg_v_total = CW'(vt);
    cfg_load = 1'b1;
  endtask

  // One clock: predict from the current inputs, clock, compare, then advance counters.
  task automatic cycle(input bit do_chk);
    int  hc, vc, hsb, vsb;
    bit  e_hs, e_vs, e_de, was_rst;
    int  e_x, e_y;
    tm_t rh, rv;
    hc  = int'(h_count);
    vc  = int'(v_count);
    hsb = m_sh_h.a + m_sh_h.fp;
    vsb = m_sh_v.a + m_sh_v.fp;
    e_de = (hc < m_sh_h.a) && (vc < m_sh_v.a);
    e_hs = (hc >= hsb && hc < hsb + m_sh_h.s) ? HS_POL : !HS_POL;
    e_vs = (vc >= vsb && vc < vsb + m_sh_v.s) ? VS_POL : !VS_POL;
    e_x  = e_de ? hc : 0;
    e_y  = e_de ? vc : 0;
    if (rst) begin
      e_hs = !HS_POL; e_vs = !VS_POL; e_de = 0; e_x = 0; e_y = 0;
      m_sh_h = mk(1280, 110, 40, 1650); m_sh_v = mk(720, 5, 5, 750);
      m_pend = 0; m_err = 0;
    end else begin
      if (frame_start && m_pend) begin
        m_sh_h = m_st_h; m_sh_v = m_st_v; m_pend = 0;
      end
      if (cfg_load) begin
        rh = mk(int'(cfg_h_active), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_total));
        rv = mk(int'(cfg_v_active), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_total));
        if (legal(rh) && legal(rv)) begin
          m_st_h = rh; m_st_v = rv; m_pend = 1; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end
    @(posedge pixel_clk);
    #1;
    if (do_chk) begin
      checks++;
      if (hsync !== e_hs || vsync !== e_vs || de !== e_de || int'(x) != e_x || int'(y) != e_y ||
          cfg_busy !== m_pend || cfg_err !== m_err || int'(h_total) != m_sh_h.t ||
          int'(v_total) != m_sh_v.t) begin
        failures++;
        $display("FAIL cycle t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d busy=%b err=%b ht=%0d vt=%0d expected hs=%b vs=%b de=%b x=%0d y=%0d busy=%b err=%b ht=%0d vt=%0d",
                 $time, hsync, vsync, de, x, y, cfg_busy, cfg_err, h_total, v_total,
                 e_hs, e_vs, e_de, e_x, e_y, m_pend, m_err, m_sh_h.t, m_sh_v.t);
      end
    end
    was_rst  = rst;
    rst      = 1'b0;
    cfg_load = 1'b0;
    if (free_run) begin
      if (was_rst) begin
        hc = 0; vc = 0;
      end else begin
        hc = hc + 1;
        if (hc >= m_sh_h.t) begin
          hc = 0;
          vc = vc + 1;
          if (vc >= m_sh_v.t) vc = 0;
        end
      end
      h_count     = CW'(hc);
      v_count     = CW'(vc);
      frame_start = (hc == 0) && (vc == 0);
    end
  endtask

  task automatic run_to_fs(input int max_cycles);
    for (int i = 0; i < max_cycles && !frame_start; i++) cycle(1);
    chk("frame_start_reached", int'(frame_start), 1);
  endtask

  vec_t vecs[13];
  int   xq[$];
  int   yq[$];

  initial begin
    m_sh_h = mk(1280, 110, 40, 1650); m_sh_v = mk(720, 5, 5, 750);
    m_st_h = m_sh_h; m_st_v = m_sh_v; m_pend = 0; m_err = 0;
    rst = 1'b1; frame_start = 1'b1; h_count = '0; v_count = '0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    cfg_load = 1'b0;

    // Reset state
    rst = 1'b1; cycle(1);
    rst = 1'b1; cycle(1);
    chk("rst_h_total", int'(h_total), 1650);
    chk("rst_v_total", int'(v_total), 750);
    chk("rst_busy", int'(cfg_busy), 0);

    // 720p decode table
    vecs = '{
      '{1389, 0, 0, 0, 0}, '{1390, 0, 1, 0, 0}, '{1429, 0, 1, 0, 0}, '{1430, 0, 0, 0, 0},
      '{0, 0, 0, 0, 1},    '{1279, 719, 0, 0, 1}, '{1280, 0, 0, 0, 0}, '{0, 720, 0, 0, 0},
      '{5, 724, 0, 0, 0},  '{5, 725, 0, 1, 0},  '{5, 729, 0, 1, 0},  '{5, 730, 0, 0, 0},
      '{4095, 749, 0, 0, 0}
    };
    free_run = 1'b0;
    frame_start = 1'b0;
    foreach (vecs[i]) begin
      h_count = CW'(vecs[i].hc); v_count = CW'(vecs[i].vc);
      cycle(1);
      chk("tbl_hsync", int'(hsync), int'(vecs[i].hs));
      chk("tbl_vsync", int'(vsync), int'(vecs[i].vs));
      chk("tbl_de", int'(de), int'(vecs[i].de));
    end
    for (int h = 1390; h < 1430; h++) begin
      h_count = CW'(h); v_count = '0;
      cycle(1);
      chk("hsync_window", int'(hsync), 1);
    end

    // Small config loaded mid-frame
    free_run = 1'b1;
    h_count = CW'(100); v_count = CW'(3); frame_start = 1'b0;
    set_cfg(4, 1, 2, 10, 2, 1, 1, 5);
    cycle(1);
    chk("small_busy", int'(cfg_busy), 1);
    for (int i = 0; i < 5; i++) cycle(1);
    chk("small_busy_hold", int'(cfg_busy), 1);
    chk("small_h_total_old", int'(h_total), 1650);
    h_count = CW'(1648); v_count = CW'(749);
    run_to_fs(5);
    cycle(1);
    chk("small_h_total_new", int'(h_total), 10);
    chk("small_busy_clear", int'(cfg_busy), 0);
    run_to_fs(60);
    xq.delete(); yq.delete();
    for (int i = 0; i < 50; i++) begin
      cycle(1);
      if (de) begin
        xq.push_back(int'(x));
        yq.push_back(int'(y));
      end
    end
    chk("small_de_count", xq.size(), 8);
    for (int i = 0; i < 8 && i < xq.size(); i++) begin
      chk("small_x", xq[i], i % 4);
      chk("small_y", yq[i], i / 4);
    end

    // Invalid load then recovery
    set_cfg(8, 1, 1, 10, 2, 1, 1, 5);
    cycle(1);
    chk("inv_err", int'(cfg_err), 1);
    chk("inv_busy", int'(cfg_busy), 0);
    chk("inv_h_total", int'(h_total), 10);
    set_cfg(4, 1, 2, 12, 2, 1, 1, 5);
    cycle(1);
    chk("valid_err_clear", int'(cfg_err), 0);
    chk("valid_busy", int'(cfg_busy), 1);

    // New request coincident with frame_start while pending
    run_to_fs(60);
    set_cfg(6, 2, 1, 16, 3, 1, 1, 7);
    cycle(1);
    chk("coinc_h_total", int'(h_total), 12);
    chk("coinc_busy", int'(cfg_busy), 1);
    run_to_fs(80);
    cycle(1);
    chk("coinc2_h_total", int'(h_total), 16);
    chk("coinc2_v_total", int'(v_total), 7);
    chk("coinc2_busy", int'(cfg_busy), 0);

    // Reset while pending, counts inside the active area
    set_cfg(5, 1, 1, 9, 2, 1, 1, 5);
    cycle(1);
    chk("pend_busy", int'(cfg_busy), 1);
    h_count = CW'(1); v_count = '0; frame_start = 1'b0;
    rst = 1'b1;
    cycle(1);
    chk("rstp_busy", int'(cfg_busy), 0);
    chk("rstp_h_total", int'(h_total), 1650);
    chk("rstp_de", int'(de), 0);
    chk("rstp_hsync", int'(hsync), int'(!HS_POL));

`ifdef VIDEO_SYNC_GEN_PATTERN_EN
    begin
      logic [23:0] bars [8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      set_cfg(16, 1, 1, 20, 2, 1, 1, 4);
      cycle(1);
      run_to_fs(1700000);
      for (int i = 0; i < 80; i++) begin
        cycle(1);
        if (!de) chk("rgb_blank", int'(rgb), 0);
        else if (y != '0) chk("rgb_bar", int'(rgb), int'(bars[int'(x) / 2]));
      end
    end
`endif

    // Randomized counts, frame_starts, loads and resets against the model
    free_run = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        h_count = CW'($urandom_range(0, 24)); v_count = CW'($urandom_range(0, 12));
      end else begin
        h_count = CW'($urandom_range(0, 1800)); v_count = CW'($urandom_range(0, 800));
      end
      frame_start = ($urandom_range(0, 15) == 0);
      if (frame_start) begin
        h_count = '0; v_count = '0;
      end
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0)
          set_cfg($urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 20),
                  $urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 12));
        else
          set_cfg($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
